// File: rtl/store_merge_seq_if.sv
// Bus bundle for store_merge_seq: control handshake, store operands and the memory read port.
// The master side is the control FSM together with the memory; the slave side is the store-size stage.
interface store_merge_seq_if;
    logic        start;
    logic [1:0]  ss_ctrl;
    logic [31:0] addr;
    logic [31:0] b_in;
    logic [31:0] mem_rdata;
    logic        mem_rd_req;
    logic [31:0] mem_addr;
    logic [31:0] storesize_out;
    logic        busy;
    logic        done;
    logic        misalign_err;

    modport master (
        output start, ss_ctrl, addr, b_in, mem_rdata,
        input  mem_rd_req, mem_addr, storesize_out, busy, done, misalign_err
    );

    modport slave (
        input  start, ss_ctrl, addr, b_in, mem_rdata,
        output mem_rd_req, mem_addr, storesize_out, busy, done, misalign_err
    );
endinterface

// File: rtl/store_merge_seq.sv
// Store-size stage: builds the sw/sh/sb store word, merging sub-word data into the aligned memory word.
// Optional macro MISALIGN_CHECK_EN: flags misaligned sh/sw and completes them without a read.
module store_merge_seq #(
    parameter int unsigned MEM_LAT = 1
) (
    input logic         clk,
    input logic         reset,
    store_merge_seq_if.slave bus
);
    localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        MERGE,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [1:0]    ctrl_q;
    logic [1:0]    lane_q;
    logic [31:0]   b_q;
    logic [31:0]   rdata_q;
    logic [31:0]   mem_addr_q;
    logic [31:0]   store_q;
    logic [CW-1:0] cnt;
    logic [31:0]   merged;

    logic          start_sw;
    logic          start_sh;
    logic          misalign;

    // Reserved encoding 11 behaves as a full-word store.
    assign start_sw = (bus.ss_ctrl == 2'b00) || (bus.ss_ctrl == 2'b11);
    assign start_sh = (bus.ss_ctrl == 2'b01);

`ifdef MISALIGN_CHECK_EN
    logic mis_q;
    assign misalign = (start_sh && bus.addr[0]) || (start_sw && (bus.addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (start_sw || misalign) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = READ;
                    end
                end
            end
            READ:    state_nx = WAIT;
            WAIT:    if (cnt == '0) state_nx = MERGE;
            MERGE:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Little-endian lane merge of the captured operands into the captured memory word.
    always_comb begin
        merged = rdata_q;
        case (ctrl_q)
            2'b10: merged[{lane_q, 3'b000} +: 8] = b_q[7:0];
            2'b01: begin
                if (lane_q[1]) begin
                    merged[31:16] = b_q[15:0];
                end else begin
                    merged[15:0] = b_q[15:0];
                end
            end
            default: merged = b_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ctrl_q     <= '0;
            lane_q     <= '0;
            b_q        <= '0;
            rdata_q    <= '0;
            mem_addr_q <= '0;
            store_q    <= '0;
            cnt        <= '0;
`ifdef MISALIGN_CHECK_EN
            mis_q      <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ctrl_q     <= bus.ss_ctrl;
                        lane_q     <= bus.addr[1:0];
                        b_q        <= bus.b_in;
                        mem_addr_q <= {bus.addr[31:2], 2'b00};
`ifdef MISALIGN_CHECK_EN
                        mis_q      <= misalign;
`endif
                        // A full-word store needs no read; its result is ready for the DONE cycle.
                        if (start_sw && !misalign) begin
                            store_q <= bus.b_in;
                        end
                    end
                end
                READ: cnt <= CW'(MEM_LAT - 1);
                WAIT: begin
                    if (cnt == '0) begin
                        rdata_q <= bus.mem_rdata;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MERGE:   store_q <= merged;
                default: ;
            endcase
        end
    end

    assign bus.mem_rd_req    = (state == READ);
    assign bus.mem_addr      = mem_addr_q;
    assign bus.storesize_out = store_q;
    assign bus.busy          = (state != IDLE);
    assign bus.done          = (state == DONE);
`ifdef MISALIGN_CHECK_EN
    assign bus.misalign_err  = (state == DONE) && mis_q;
`else
    assign bus.misalign_err  = 1'b0;
`endif

endmodule

// File: tb/tb_store_merge_seq.sv
// Scoreboard bench for store_merge_seq: instance 0 uses MEM_LAT=1, instance 1 uses MEM_LAT=3.
// Stimulus pushes expected results; a per-instance monitor pops and compares on every done pulse.
module tb_store_merge_seq;
    typedef struct {
        logic [31:0] data;
        logic        err;
        int unsigned lat;
        int unsigned reads;
        logic [31:0] maddr;
        int unsigned t0;
    } exp_t;

    logic        clk;
    logic        reset;
    int unsigned cyc;
    int unsigned checks;
    int unsigned errors;

    logic        start_v [2];
    logic [1:0]  ctrl_v  [2];
    logic [31:0] addr_v  [2];
    logic [31:0] b_v     [2];
    logic [31:0] so_v    [2];
    logic [31:0] maddr_v [2];
    logic        req_v   [2];
    logic        busy_v  [2];
    logic        done_v  [2];
    logic        err_v   [2];
    logic [31:0] last_d  [2];

    exp_t expq [2][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 1 : 3;
        logic [3:0] pipe;

        store_merge_seq_if ifc ();

        store_merge_seq #(.MEM_LAT(L)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (ifc)
        );

        assign ifc.start   = start_v[g];
        assign ifc.ss_ctrl = ctrl_v[g];
        assign ifc.addr    = addr_v[g];
        assign ifc.b_in    = b_v[g];
        assign so_v[g]     = ifc.storesize_out;
        assign maddr_v[g]  = ifc.mem_addr;
        assign req_v[g]    = ifc.mem_rd_req;
        assign busy_v[g]   = ifc.busy;
        assign done_v[g]   = ifc.done;
        assign err_v[g]    = ifc.misalign_err;

        // Memory model: data is valid only in the cycle exactly L cycles after the request.
        always @(posedge clk) begin
            if (reset) pipe <= '0;
            else       pipe <= {pipe[2:0], ifc.mem_rd_req};
        end
        assign ifc.mem_rdata = pipe[L-1] ? 32'h1122_3344 : 32'hA5A5_A5A5;

        initial begin : mon
            int unsigned reads;
            exp_t x;
            reads = 0;
            forever begin
                @(posedge clk);
                #1;
                if (reset) begin
                    reads = 0;
                end else begin
                    if (ifc.mem_rd_req) begin
                        reads++;
                        if (expq[g].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL inst%0d unexpected_read: got read expected none", g);
                        end else begin
                            chk($sformatf("inst%0d rd_addr", g), ifc.mem_addr, expq[g][0].maddr);
                            chk($sformatf("inst%0d rd_cycle", g), cyc - expq[g][0].t0, 32'd1);
                        end
                    end
                    if (ifc.done) begin
                        if (expq[g].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL inst%0d spurious_done: got done expected none", g);
                        end else begin
                            x = expq[g].pop_front();
                            chk($sformatf("inst%0d data", g), ifc.storesize_out, x.data);
                            chk($sformatf("inst%0d misalign_err", g), {31'd0, ifc.misalign_err}, {31'd0, x.err});
                            chk($sformatf("inst%0d done_latency", g), cyc - x.t0, x.lat);
                            chk($sformatf("inst%0d read_count", g), reads, x.reads);
                        end
                        reads = 0;
                    end
                end
            end
        end
    end

    task automatic push(input int g, input logic [31:0] a, input logic [31:0] d, input logic e,
                        input int unsigned lat, input int unsigned rd);
        exp_t x;
        x = '{data: d, err: e, lat: lat, reads: rd, maddr: a & 32'hFFFF_FFFC, t0: cyc};
        expq[g].push_back(x);
        if (!e) last_d[g] = d;
    endtask

    task automatic issue(input int g, input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] d, input logic e, input int unsigned lat, input int unsigned rd);
        @(negedge clk);
        start_v[g] = 1'b1;
        ctrl_v[g]  = c;
        addr_v[g]  = a;
        b_v[g]     = b;
        push(g, a, d, e, lat, rd);
        @(negedge clk);
        start_v[g] = 1'b0;
        ctrl_v[g]  = 2'($urandom);
        addr_v[g]  = $urandom;
        b_v[g]     = $urandom;
    endtask

    task automatic drain(input int g);
        for (int i = 0; i < 40 && expq[g].size() != 0; i++) @(negedge clk);
        if (expq[g].size() != 0) begin
            checks++;
            errors++;
            $display("FAIL inst%0d drain_timeout: got %0d pending expected 0", g, expq[g].size());
            expq[g].delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_idle(input int g, input string tag);
        chk($sformatf("inst%0d %s storesize_out", g, tag), so_v[g], 32'd0);
        chk($sformatf("inst%0d %s mem_addr", g, tag), maddr_v[g], 32'd0);
        chk($sformatf("inst%0d %s flags", g, tag),
            {28'd0, req_v[g], busy_v[g], done_v[g], err_v[g]}, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin : stim
        cyc    = 0;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        for (int g = 0; g < 2; g++) begin
            start_v[g] = 1'b0;
            ctrl_v[g]  = 2'b00;
            addr_v[g]  = '0;
            b_v[g]     = '0;
            last_d[g]  = '0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) check_idle(g, "reset");
        reset = 1'b0;

        // Instance 0, MEM_LAT=1: sub-word lane merges and full-word stores.
        issue(0, 2'b10, 32'h0000_0102, 32'h0000_00AB, 32'h11AB_3344, 1'b0, 4, 1); drain(0);
        issue(0, 2'b01, 32'h0000_0102, 32'h0000_BEEF, 32'hBEEF_3344, 1'b0, 4, 1); drain(0);
        issue(0, 2'b01, 32'h0000_0100, 32'h9999_BEEF, 32'h1122_BEEF, 1'b0, 4, 1); drain(0);
        issue(0, 2'b00, 32'h0000_0200, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1, 0); drain(0);
        issue(0, 2'b10, 32'h0000_0100, 32'h1234_5699, 32'h1122_3399, 1'b0, 4, 1); drain(0);
        issue(0, 2'b10, 32'h0000_0101, 32'h0000_005A, 32'h1122_5A44, 1'b0, 4, 1); drain(0);
        issue(0, 2'b11, 32'h0000_0300, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1, 0); drain(0);
`ifdef MISALIGN_CHECK_EN
        issue(0, 2'b00, 32'h0000_0302, 32'h1357_9BDF, last_d[0], 1'b1, 1, 0); drain(0);
        issue(0, 2'b01, 32'h0000_0101, 32'h0000_BEEF, last_d[0], 1'b1, 1, 0); drain(0);
`else
        issue(0, 2'b00, 32'h0000_0302, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 1, 0); drain(0);
        issue(0, 2'b01, 32'h0000_0101, 32'h0000_BEEF, 32'h1122_BEEF, 1'b0, 4, 1); drain(0);
`endif

        // start held through the DONE cycle is ignored; the first IDLE cycle after DONE is accepted.
        @(negedge clk);
        start_v[0] = 1'b1; ctrl_v[0] = 2'b00; addr_v[0] = 32'h40; b_v[0] = 32'h0A0A_0A0A;
        push(0, 32'h40, 32'h0A0A_0A0A, 1'b0, 1, 0);
        @(negedge clk);
        b_v[0] = 32'h0B0B_0B0B;
        @(negedge clk);
        b_v[0] = 32'h0C0C_0C0C;
        push(0, 32'h40, 32'h0C0C_0C0C, 1'b0, 1, 0);
        @(negedge clk);
        start_v[0] = 1'b0;
        drain(0);

        // start pulsed during WAIT is ignored.
        issue(0, 2'b10, 32'h0000_0102, 32'h0000_00AB, 32'h11AB_3344, 1'b0, 4, 1);
        @(negedge clk);
        chk("inst0 busy_in_wait", {31'd0, busy_v[0]}, 32'd1);
        start_v[0] = 1'b1; ctrl_v[0] = 2'b00; b_v[0] = 32'h7777_7777;
        @(negedge clk);
        start_v[0] = 1'b0;
        drain(0);

        // Instance 1, MEM_LAT=3.
        issue(1, 2'b10, 32'h0000_0103, 32'h0000_00CD, 32'hCD22_3344, 1'b0, 6, 1); drain(1);
        issue(1, 2'b01, 32'h0000_0102, 32'h0000_BEEF, 32'hBEEF_3344, 1'b0, 6, 1); drain(1);

        // Reset during WAIT: back to IDLE with cleared outputs and no late done.
        issue(1, 2'b10, 32'h0000_0101, 32'h0000_0011, 32'h1122_1144, 1'b0, 6, 1);
        @(negedge clk);
        reset = 1'b1;
        expq[1].delete();
        @(negedge clk);
        reset = 1'b0;
        check_idle(1, "mid_reset");
        check_idle(0, "mid_reset");
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
